// File: rtl/img_pkg.sv
// Shared definitions for the 3x3 window generator: window indices and FSM states.
// Used by window_gen_3x3 (optional coordinates via WINDOW_GEN_COORD_EN).
package img_pkg;

  localparam int WIN_TL     = 0;
  localparam int WIN_TC     = 1;
  localparam int WIN_TR     = 2;
  localparam int WIN_ML     = 3;
  localparam int WIN_CENTER = 4;
  localparam int WIN_MR     = 5;
  localparam int WIN_BL     = 6;
  localparam int WIN_BC     = 7;
  localparam int WIN_BR     = 8;
  localparam int WIN_SIZE   = 9;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    STREAM
  } win_state_t;

endpackage

// File: rtl/line_buffer.sv
// Single-line pixel store: asynchronous read and synchronous write at one address,
// so a same-cycle read returns the old contents (read-before-write).
module line_buffer #(
  parameter int DEPTH = 640,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [0:DEPTH-1];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/window_gen_3x3.sv
// Raster stream to registered 3x3 interior windows using two line buffers.
// Define WINDOW_GEN_COORD_EN to add center_x/center_y outputs.
module window_gen_3x3
  import img_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] pixel_in,
  input  logic                  pixel_valid,
  input  logic                  frame_start,
  output logic [DATA_WIDTH-1:0] window [0:WIN_SIZE-1],
  output logic                  window_valid,
  output logic                  frame_done
`ifdef WINDOW_GEN_COORD_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  center_x,
  output logic [$clog2(IMG_HEIGHT)-1:0] center_y
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  win_state_t state_q, state_d;

  logic [CW-1:0] col_q, col_d, col_cur;
  logic [RW-1:0] row_q, row_d, row_cur;

  logic accept, restart, eol, eof;
  logic valid_q, valid_d;
  logic done_q, done_d;

  logic [DATA_WIDTH-1:0] lb0_rd, lb1_rd;
  logic [DATA_WIDTH-1:0] win_q [0:WIN_SIZE-1];
  logic [DATA_WIDTH-1:0] win_d [0:WIN_SIZE-1];

  always_comb begin
    restart = pixel_valid && frame_start;
    accept  = pixel_valid && ((state_q != IDLE) || frame_start);
    col_cur = restart ? '0 : col_q;
    row_cur = restart ? '0 : row_q;
    eol     = (col_cur == COL_LAST);
    eof     = eol && (row_cur == ROW_LAST);
  end

  // lb1 holds line r-1; its old word cascades into lb0 (line r-2)
  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH),
    .AW    (CW)
  ) u_lb1 (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (col_cur),
    .wdata_i (pixel_in),
    .rdata_o (lb1_rd)
  );

  line_buffer #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH),
    .AW    (CW)
  ) u_lb0 (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (col_cur),
    .wdata_i (lb1_rd),
    .rdata_o (lb0_rd)
  );

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    win_d   = win_q;
    if (accept) begin
      col_d   = eol ? '0 : col_cur + CW'(1);
      row_d   = eol ? row_cur + RW'(1) : row_cur;
      valid_d = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
      win_d[WIN_TL]     = win_q[WIN_TC];
      win_d[WIN_TC]     = win_q[WIN_TR];
      win_d[WIN_TR]     = lb0_rd;
      win_d[WIN_ML]     = win_q[WIN_CENTER];
      win_d[WIN_CENTER] = win_q[WIN_MR];
      win_d[WIN_MR]     = lb1_rd;
      win_d[WIN_BL]     = win_q[WIN_BC];
      win_d[WIN_BC]     = win_q[WIN_BR];
      win_d[WIN_BR]     = pixel_in;
      unique case (1'b1)
        restart: state_d = FILL;
        (state_q == FILL) && eol && (row_cur == ROW_ONE):
          state_d = STREAM;
        (state_q == STREAM) && eof: begin
          state_d = IDLE;
          done_d  = 1'b1;
          col_d   = '0;
          row_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      win_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_q   <= win_d;
    end
  end

  assign window       = win_q;
  assign window_valid = valid_q;
  assign frame_done   = done_q;

`ifdef WINDOW_GEN_COORD_EN
  logic [CW-1:0] cx_q, cx_d;
  logic [RW-1:0] cy_q, cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (accept) begin
      cx_d = col_cur - CW'(1);
      cy_d = row_cur - RW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign center_x = cx_q;
  assign center_y = cy_q;
`endif

endmodule

// File: tb/tb_window_gen_3x3.sv
// Directed bench for window_gen_3x3 on a 4x4 image with a frame-level model.
// Compare process checks outputs every cycle against the model's expectation.
module tb_window_gen_3x3;

  localparam int W = 4;
  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pixel_in;
  logic       pixel_valid;
  logic       frame_start;
  logic [7:0] window [0:8];
  logic       window_valid;
  logic       frame_done;
`ifdef WINDOW_GEN_COORD_EN
  logic [1:0] center_x;
  logic [1:0] center_y;
`endif

  window_gen_3x3 #(
    .DATA_WIDTH (8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .pixel_in     (pixel_in),
    .pixel_valid  (pixel_valid),
    .frame_start  (frame_start),
    .window       (window),
    .window_valid (window_valid),
    .frame_done   (frame_done)
`ifdef WINDOW_GEN_COORD_EN
    ,
    .center_x     (center_x),
    .center_y     (center_y)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [71:0] got,
                     input logic [71:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // frame-level model: the pixels of the current frame plus its scan position
  logic [7:0] img [0:H-1][0:W-1];
  bit  active = 0;
  int  mr = 0;
  int  mc = 0;

  bit          pend_valid = 0, pend_done = 0, pend_zero = 1;
  logic [71:0] pend_win = '0;
  int          pend_cx = 0, pend_cy = 0;
  bit          cur_valid = 0, cur_done = 0, cur_zero = 0;
  logic [71:0] cur_win = '0;
  int          cur_cx = 0, cur_cy = 0;
  bit          started = 0;

  int          win_cnt = 0;
  int          done_cnt = 0;
  logic [71:0] got [$];
  logic [3:0]  coords [$];

  function automatic logic [71:0] mkwin(input int r, input int c);
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w = (w << 8) | 72'(img[r-2+i][c-2+j]);
    return w;
  endfunction

  function automatic logic [71:0] pk();
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w = (w << 8) | 72'(window[i]);
    return w;
  endfunction

  task automatic model(input bit pv, input bit fs, input logic [7:0] px,
                       input bit rn);
    pend_valid = 0;
    pend_done  = 0;
    pend_zero  = 0;
    if (!rn) begin
      active    = 0;
      pend_zero = 1;
    end else if (pv) begin
      if (fs) begin
        active = 1;
        mr = 0;
        mc = 0;
      end
      if (active) begin
        img[mr][mc] = px;
        if (mr >= 2 && mc >= 2) begin
          pend_valid = 1;
          pend_win   = mkwin(mr, mc);
          pend_cx    = mc - 1;
          pend_cy    = mr - 1;
        end
        if (mr == H-1 && mc == W-1) begin
          pend_done = 1;
          active    = 0;
        end else if (mc == W-1) begin
          mc = 0;
          mr++;
        end else begin
          mc++;
        end
      end
    end
  endtask

  task automatic step(input bit pv, input bit fs, input logic [7:0] px,
                      input bit rn);
    @(posedge clk);
    #2;
    cur_valid = pend_valid;
    cur_done  = pend_done;
    cur_zero  = pend_zero;
    cur_win   = pend_win;
    cur_cx    = pend_cx;
    cur_cy    = pend_cy;
    started   = 1;
    pixel_valid = pv;
    frame_start = fs;
    pixel_in    = px;
    rst         = rn;
    model(pv, fs, px, rn);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, 1);
  endtask

  task automatic send_frame(input logic [7:0] base, input int gap_after);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        step(1, (r == 0 && c == 0), base | 8'((r << 4) | c), 1);
        if (r * W + c == gap_after) idle(3);
      end
    idle(3);
  endtask

  task automatic clear_counts();
    win_cnt  = 0;
    done_cnt = 0;
    got.delete();
    coords.delete();
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("window_valid", 72'(window_valid), 72'(cur_valid));
      chk("frame_done", 72'(frame_done), 72'(cur_done));
      if (cur_valid || cur_zero)
        chk("window", pk(), cur_zero ? 72'h0 : cur_win);
`ifdef WINDOW_GEN_COORD_EN
      if (cur_valid) begin
        chk("center_x", 72'(center_x), 72'(cur_cx));
        chk("center_y", 72'(center_y), 72'(cur_cy));
      end
      if (cur_zero) chk("center_zero", 72'({center_x, center_y}), 72'h0);
`endif
      if (window_valid) begin
        got.push_back(pk());
        win_cnt++;
`ifdef WINDOW_GEN_COORD_EN
        coords.push_back({center_x, center_y});
`endif
      end
      if (frame_done) done_cnt++;
    end
  end

  logic [71:0] t1 [$];

  initial begin
    rst         = 1'b0;
    pixel_valid = 1'b0;
    frame_start = 1'b0;
    pixel_in    = 8'h00;
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    idle(2);

    // basic frame
    clear_counts();
    send_frame(8'h00, -1);
    chk("t1_count", 72'(win_cnt), 72'd4);
    chk("t1_done", 72'(done_cnt), 72'd1);
    chk("t1_first", got[0], 72'h000102101112202122);
    chk("t1_last", got[got.size()-1], 72'h111213212223313233);
`ifdef WINDOW_GEN_COORD_EN
    chk("t1_xy0", 72'(coords[0]), 72'h5);
    chk("t1_xy1", 72'(coords[1]), 72'h9);
    chk("t1_xy2", 72'(coords[2]), 72'h6);
    chk("t1_xy3", 72'(coords[3]), 72'ha);
`endif
    t1 = got;

    // stall after pixel 0x21 (index 9)
    clear_counts();
    send_frame(8'h00, 9);
    chk("t2_count", 72'(win_cnt), 72'd4);
    chk("t2_done", 72'(done_cnt), 72'd1);
    for (int i = 0; i < 4; i++) chk("t2_same", got[i], t1[i]);

    // pixels without frame_start after reset are dropped
    step(0, 0, 8'h00, 0);
    clear_counts();
    for (int i = 0; i < 6; i++) step(1, 0, 8'(8'h40 + i), 1);
    idle(2);
    chk("t3_none", 72'(win_cnt), 72'd0);
    chk("t3_nodone", 72'(done_cnt), 72'd0);
    clear_counts();
    send_frame(8'h00, -1);
    chk("t3_count", 72'(win_cnt), 72'd4);
    chk("t3_first", got[0], 72'h000102101112202122);

    // abort at (2,1) with a fresh 0x80 frame
    clear_counts();
    for (int i = 0; i < 9; i++)
      step(1, (i == 0), 8'(((i / W) << 4) | (i % W)), 1);
    send_frame(8'h80, -1);
    chk("t4_count", 72'(win_cnt), 72'd4);
    chk("t4_done", 72'(done_cnt), 72'd1);
    chk("t4_first", got[0], 72'h808182909192a0a1a2);
    chk("t4_last", got[3], 72'h919293a1a2a3b1b2b3);

    // reset pulse at pixel (3,0)
    clear_counts();
    for (int i = 0; i < 12; i++)
      step(1, (i == 0), 8'(((i / W) << 4) | (i % W)), 1);
    step(1, 0, 8'h30, 0);
    for (int c = 1; c < W; c++) step(1, 0, 8'(8'h30 | c), 1);
    idle(2);
    chk("t5_partial", 72'(win_cnt), 72'd2);
    chk("t5_nodone", 72'(done_cnt), 72'd0);
    clear_counts();
    send_frame(8'h00, -1);
    chk("t5_count", 72'(win_cnt), 72'd4);
    chk("t5_done", 72'(done_cnt), 72'd1);
    chk("t5_first", got[0], 72'h000102101112202122);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
